// File: rtl/spi_slave.sv
// SPI slave front end: receives 10-bit {cmd, payload} frames MSB-first on MOSI and,
// after a read-data frame, returns one RAM byte MSB-first on MISO.
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       MOSI,
    input  logic       SS_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       MISO,
    output logic       rx_valid,
    output logic [9:0] rx_data
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t      state_reg;
    logic        rd_addr_done_reg;
    logic [3:0]  bit_cnt_reg;
    logic [8:0]  shift_reg;
    logic [7:0]  tx_shift_reg;
    logic [2:0]  tx_cnt_reg;
    logic        tx_busy_reg;
    logic        tx_done_reg;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg        <= IDLE;
            rd_addr_done_reg <= 1'b0;
            bit_cnt_reg      <= 4'd0;
            shift_reg        <= 9'd0;
            tx_shift_reg     <= 8'd0;
            tx_cnt_reg       <= 3'd0;
            tx_busy_reg      <= 1'b0;
            tx_done_reg      <= 1'b0;
            MISO             <= 1'b0;
            rx_valid         <= 1'b0;
            rx_data          <= 10'd0;
        end else begin
            rx_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    MISO         <= 1'b0;
                    bit_cnt_reg  <= 4'd0;
                    tx_shift_reg <= 8'd0;
                    tx_cnt_reg   <= 3'd0;
                    tx_busy_reg  <= 1'b0;
                    tx_done_reg  <= 1'b0;
                    if (!SS_n)
                        state_reg <= CHK_CMD;
                end

                CHK_CMD: begin
                    if (SS_n) begin
                        state_reg <= IDLE;
                    end else begin
                        shift_reg   <= {8'd0, MOSI};
                        bit_cnt_reg <= 4'd0;
                        if (!MOSI)
                            state_reg <= WRITE;
                        else if (!rd_addr_done_reg)
                            state_reg <= READ_ADD;
                        else
                            state_reg <= READ_DATA;
                    end
                end

                default: begin
                    if (SS_n) begin
                        state_reg    <= IDLE;
                        bit_cnt_reg  <= 4'd0;
                        tx_shift_reg <= 8'd0;
                        tx_cnt_reg   <= 3'd0;
                        tx_busy_reg  <= 1'b0;
                        tx_done_reg  <= 1'b0;
                        MISO         <= 1'b0;
                    end else if (bit_cnt_reg != 4'd9) begin
                        // bit_cnt counts payload bits 8..0; the ninth one closes the frame
                        shift_reg   <= {shift_reg[7:0], MOSI};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd8) begin
                            rx_data  <= {shift_reg, MOSI};
                            rx_valid <= 1'b1;
                            if (state_reg == READ_ADD)
                                rd_addr_done_reg <= 1'b1;
                        end
                    end else if (state_reg == READ_DATA) begin
                        if (tx_busy_reg) begin
                            if (tx_cnt_reg != 3'd0) begin
                                MISO         <= tx_shift_reg[7];
                                tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                                tx_cnt_reg   <= tx_cnt_reg - 3'd1;
                            end else begin
                                MISO        <= 1'b0;
                                tx_busy_reg <= 1'b0;
                                tx_done_reg <= 1'b1;
                            end
                        end else if (!tx_done_reg && tx_valid) begin
                            // bit 7 goes straight out; the remaining 7 wait in the shifter
                            MISO             <= tx_data[7];
                            tx_shift_reg     <= {tx_data[6:0], 1'b0};
                            tx_cnt_reg       <= 3'd7;
                            tx_busy_reg      <= 1'b1;
                            rd_addr_done_reg <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Randomized scoreboard bench for spi_slave: stimulus pushes expected frames/bytes,
// independent monitors pop and compare against rx_valid/rx_data and the MISO stream.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       MOSI;
    logic       SS_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       MISO;
    logic       rx_valid;
    logic [9:0] rx_data;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MOSI     (MOSI),
        .SS_n     (SS_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .MISO     (MISO),
        .rx_valid (rx_valid),
        .rx_data  (rx_data)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] rx_q[$];
    logic [7:0] tx_q[$];
    bit         mon_en = 1'b0;

    // Reference model state: frame semantics only
    bit         model_rd_done = 1'b0;
    logic [9:0] model_last_rx = 10'd0;

    logic [7:0] mon_cur = 8'd0;
    int         mon_idx = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // rx monitor: every rx_valid strobe must match the oldest expected frame
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rx_valid !== 1'b0) begin
                if (rx_q.size() == 0) begin
                    check("rx_unexpected_valid", {31'd0, rx_valid}, 32'd0);
                end else begin
                    check("rx_data", {22'd0, rx_data}, {22'd0, rx_q.pop_front()});
                end
            end
        end
    end

    // MISO monitor: a byte stream starts when an expected byte is offered; otherwise MISO must be 0
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (tx_valid === 1'b1 && tx_q.size() > 0) begin
                    mon_cur = tx_q.pop_front();
                    mon_idx = 7;
                end
                if (mon_idx >= 0) begin
                    check("miso_bit", {31'd0, MISO}, {31'd0, mon_cur[mon_idx]});
                    mon_idx--;
                end else begin
                    check("miso_idle", {31'd0, MISO}, 32'd0);
                end
            end
        end
    end

    // nbits < 10 aborts the frame; tx_delay < 0 means no tx_valid, hold idle cycles instead
    task automatic send_frame(input logic [9:0] f, input int nbits, input int tx_delay,
                              input logic [7:0] txb, input int hold);
        bit full       = (nbits == 10);
        bit is_rd_data = f[9] && model_rd_done;
        if (full) begin
            rx_q.push_back(f);
            model_last_rx = f;
            if (f[9] && !model_rd_done)
                model_rd_done = 1'b1;
        end
        @(negedge clk);
        SS_n     = 1'b0;
        MOSI     = 1'($urandom_range(0, 1));
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
        for (int i = 9; i > 9 - nbits; i--) begin
            @(negedge clk);
            MOSI     = f[i];
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
        end
        if (full) begin
            if (tx_delay >= 0) begin
                repeat (tx_delay) begin
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
                @(negedge clk);
                tx_valid = 1'b1;
                tx_data  = txb;
                if (is_rd_data) begin
                    tx_q.push_back(txb);
                    model_rd_done = 1'b0;
                end
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (8) @(negedge clk);
            end else begin
                repeat (hold) begin
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        tx_valid = 1'($urandom_range(0, 1));
        if (!full)
            check("abort_rx_data_kept", {22'd0, rx_data}, {22'd0, model_last_rx});
        $display("frame 0x%03h bits=%0d read_data=%0b tx_delay=%0d txb=0x%02h",
                 f, nbits, is_rd_data, tx_delay, txb);
    endtask

    task automatic reset_mid_frame(input logic [9:0] f);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'($urandom_range(0, 1));
        for (int i = 9; i > 4; i--) begin
            @(negedge clk);
            MOSI = f[i];
        end
        @(negedge clk);
        MOSI  = f[4];
        rst_n = 1'b1;
        SS_n  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        model_rd_done = 1'b0;
        model_last_rx = 10'd0;
        check("midreset_rx_data", {22'd0, rx_data}, 32'd0);
        check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midreset_miso", {31'd0, MISO}, 32'd0);
        $display("reset during bit 4 of frame 0x%03h", f);
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_rx_data", {22'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_miso", {31'd0, MISO}, 32'd0);
        rst_n  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        send_frame(10'b00_1010_0101, 10, -1, 8'h00, 2);
        send_frame(10'b01_0011_0011, 10, 1, 8'hFF, 0);
        send_frame(10'b10_0000_0111, 10, 0, 8'hFF, 0);
        send_frame(10'b11_0000_0000, 10, 3, 8'hC3, 0);
        send_frame(10'b10_1010_1010, 10, 0, 8'hFF, 0);
        send_frame(10'b01_0101_0101, 5, -1, 8'h00, 0);
        send_frame(10'b11_1111_0000, 10, 2, 8'h5A, 0);

        send_frame(10'b10_1000_0001, 10, -1, 8'h00, 1);
        reset_mid_frame(10'b11_1111_1111);
        send_frame(10'b11_1100_0011, 10, 0, 8'hFF, 0);
        send_frame(10'b11_0000_0000, 10, -1, 8'h00, 20);
        send_frame(10'b10_1111_1111, 10, 1, 8'h81, 0);

        for (int n = 0; n < 40; n++) begin
            logic [9:0] f;
            int         nbits;
            int         dly;
            f     = 10'($urandom);
            nbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : 10;
            dly   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 5));
            send_frame(f, nbits, dly, 8'($urandom), int'($urandom_range(0, 5)));
        end

        repeat (3) @(negedge clk);
        check("rx_queue_drained", rx_q.size(), 32'd0);
        check("tx_queue_drained", tx_q.size(), 32'd0);
        summary();
        $finish;
    end

endmodule
